// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel interval timer.
// Channel state encoding, default widths and the common 1 s terminal at 50 MHz.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_CNT_W    = 26;
  localparam int DEF_PRESCALE = 1;

  // Terminal value giving a period of exactly 1 s with a 50 MHz clock (N+1 ticks).
  localparam int unsigned ONE_SEC_50M = 32'd49_999_999;

endpackage

// File: rtl/multi_timer_if.sv
// Control/status bundle of the multi-channel timer; master is the client FSM side.
// Strobes are single-cycle, sampled at posedge clk; status outputs are registered.
interface multi_timer_if
  import timer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH-1:0]       periodic;
  logic [N_CH*CNT_W-1:0] load_val;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       expire_pulse;
  logic [N_CH-1:0]       expire_flag;

  modport master (
    output start, stop, periodic, load_val, clr,
    input  busy, expire_pulse, expire_flag
  );

  modport slave (
    input  start, stop, periodic, load_val, clr,
    output busy, expire_pulse, expire_flag
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, up-counter to a latched terminal, sticky flag.
// Expiry pulse is registered, one clk wide, (terminal+1) ticks after start; no backpressure.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  output logic             busy,
  output logic             expire_pulse,
  output logic             expire_flag
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] terminal;
  logic             mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      terminal     <= '0;
      mode         <= 1'b0;
      busy         <= 1'b0;
      expire_pulse <= 1'b0;
      expire_flag  <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      // An expiry later in this block overrides the clear in the same cycle.
      if (clr) expire_flag <= 1'b0;

      if (start) begin
        terminal <= load_val;
        mode     <= periodic;
        count    <= '0;
        state    <= RUN;
        busy     <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (tick) begin
              // Equality only: count never passes terminal, so all-ones terminals expire cleanly.
              if (count == terminal) begin
                expire_pulse <= 1'b1;
                expire_flag  <= 1'b1;
                if (mode) begin
                  count <= '0;
                end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                end
              end else begin
                count <= count + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// N_CH independent interval timers sharing one free-running prescaler tick.
// Period is (terminal+1)*PRESCALE clks; start does not re-phase the prescaler; no backpressure.
module multi_timer
  import timer_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic          clk,
  input  logic          reset_n,
  multi_timer_if.slave  bus
);

  logic            tick;
  logic [N_CH-1:0] busy_v;
  logic [N_CH-1:0] pulse_v;
  logic [N_CH-1:0] flag_v;

  generate
    if (PRESCALE <= 1) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pre_cnt <= '0;
        end else if (pre_cnt == PMAX) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + PW'(1);
        end
      end

      assign tick = (pre_cnt == PMAX);
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timer_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .start        (bus.start[i]),
        .stop         (bus.stop[i]),
        .periodic     (bus.periodic[i]),
        .load_val     (bus.load_val[i*CNT_W +: CNT_W]),
        .clr          (bus.clr[i]),
        .busy         (busy_v[i]),
        .expire_pulse (pulse_v[i]),
        .expire_flag  (flag_v[i])
      );
    end
  endgenerate

  assign bus.busy         = busy_v;
  assign bus.expire_pulse = pulse_v;
  assign bus.expire_flag  = flag_v;

endmodule
